bcd_to_binary_seq: RTL and testbench

// Sequential packed-BCD to unsigned binary converter (reverse double dabble); inverse of the

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_rshift_adj.sv | 15 +
 rtl/bcd_to_binary_seq.sv | 141 ++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM state encoding, used by both the BCD-to-binary
// and the binary-to-BCD converters.
package bcd_pkg;

  // Width of one packed BCD digit
  localparam int BCD_DIGIT_W = 4;

  // Largest legal decimal digit; anything above this is a coding error
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Reverse double dabble: a digit at or above 8 after a right shift
  // carried in a half-ten and must be corrected by subtracting 3
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_SUB    = 4'd3;

  // Sequential converter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_rshift_adj.sv
// Per-digit correction step of reverse double dabble: after the whole work
// register has been shifted right, a digit of 8 or more is reduced by 3.
module bcd_digit_rshift_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Subtract 3 from digits that reached the threshold, pass others through
  always_comb begin
    digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter. One right shift per
// clock with a start/done handshake; digits above 9 flag err and force bin=0.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // The result register must hold the largest decimal value the digits allow
  if (10**DIGITS - 1 >= 2**BIN_W) begin : gBadWidth
    $error("bcd_to_binary_seq: BIN_W=%0d too narrow for DIGITS=%0d", BIN_W, DIGITS);
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    work_q, work_d;
  logic [BIN_W-1:0]    result_q, result_d;
  logic                errPend_q, errPend_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                err_q, err_d;

  logic                accept;
  logic                anyBadDigit;
  logic [BCD_W+BIN_W-1:0] shiftAll;
  logic [BCD_W-1:0]    shiftWork;
  logic [BIN_W-1:0]    shiftResult;
  logic [BCD_W-1:0]    adjWork;

  // A new request is only taken while not shifting
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // The work register's LSB falls into the result register's MSB
  assign shiftAll    = {work_q, result_q} >> 1;
  assign shiftWork   = shiftAll[BCD_W+BIN_W-1:BIN_W];
  assign shiftResult = shiftAll[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : gAdj
    bcd_digit_rshift_adj uAdj (
      .digit_i (shiftWork[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adjWork[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag any non-decimal digit on the incoming word
  always_comb begin
    anyBadDigit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        anyBadDigit = 1'b1;
      end
    end
  end

  // State register; reset abandons any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: shift for BIN_W cycles, one DONE cycle, restart straight from DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; busy and done are mutually exclusive
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath next state: capture on accept, shift/adjust while shifting, and
  // load the visible result on the final step so it is valid alongside done
  always_comb begin
    work_d    = work_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    errPend_d = errPend_q;
    bin_d     = bin_q;
    err_d     = err_q;
    if (accept) begin
      work_d    = bcd;
      result_d  = '0;
      cnt_d     = '0;
      errPend_d = anyBadDigit;
    end else if (state_q == ST_SHIFT) begin
      work_d   = adjWork;
      result_d = shiftResult;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        bin_d = errPend_q ? '0 : shiftResult;
        err_d = errPend_q;
      end
    end
  end

  // Datapath registers, all cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      result_q  <= '0;
      errPend_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      result_q  <= result_d;
      errPend_q <= errPend_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  assign bin = bin_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
// Edge numbering: the accepting clock edge is edge 1, so busy is expected after
// edges 1..10 and done after edge 11.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [11:0]       bcd;
  logic [BIN_W-1:0]  bin;
  logic              busy;
  logic              done;
  logic              err;

  int total = 0;
  int bad = 0;
  int doneSeen = 0;

  // Expected {err, bin} per accepted conversion, in order
  logic [BIN_W:0] sb[$];

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: weighted digit sum, invalid digits force {1, 0}
  function automatic logic [BIN_W:0] refModel(input logic [11:0] v);
    logic       isBad;
    int         val;
    logic [3:0] d;
    isBad = 1'b0;
    val = 0;
    for (int i = 2; i >= 0; i--) begin
      d = v[i*4 +: 4];
      if (d > 4'd9) isBad = 1'b1;
      val = val * 10 + int'(d);
    end
    return isBad ? {1'b1, {BIN_W{1'b0}}} : {1'b0, BIN_W'(val)};
  endfunction

  // Scoreboard consumer: every done pulse pops and checks one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneSeen++;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_with_done: busy=%b required 0", busy);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got bin=%0d err=%b, nothing expected", bin, err);
      end else begin
        logic [BIN_W:0] exp;
        exp = sb.pop_front();
        if ({err, bin} !== exp) begin
          bad++;
          $display("FAIL result: got bin=%0d err=%b required bin=%0d err=%b",
                   bin, err, exp[BIN_W-1:0], exp[BIN_W]);
        end
      end
    end
  end

  // Start one conversion and check the busy/done timeline edge by edge;
  // repulseAt != 0 re-asserts start with 12'h777 at that edge while busy
  task automatic runConversion(input logic [11:0] v, input int repulseAt);
    start = 1'b1;
    bcd = v;
    sb.push_back(refModel(v));
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        bcd = 12'($urandom);
      end
      if (repulseAt != 0 && k == repulseAt - 1) begin
        start = 1'b1;
        bcd = 12'h777;
      end
      if (repulseAt != 0 && k == repulseAt) start = 1'b0;
      total++;
      if (busy !== (k <= 10)) begin
        bad++;
        $display("FAIL busy_edge%0d: got %b required %b (bcd=%h)", k, busy, (k <= 10), v);
      end
      total++;
      if (done !== (k == 11)) begin
        bad++;
        $display("FAIL done_edge%0d: got %b required %b (bcd=%h)", k, done, (k == 11), v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bcd = 12'h000;
    #12;
    total++;
    if ({bin, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL reset_state: got bin=%0d busy=%b done=%b err=%b required all 0",
               bin, busy, done, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bin, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: got bin=%0d busy=%b done=%b err=%b required all 0",
               bin, busy, done, err);
    end
  endtask

  task automatic test_basic();
    runConversion(12'h255, 0);
    total++;
    if (bin !== 10'd255 || err !== 1'b0) begin
      bad++;
      $display("FAIL basic_255: got bin=%0d err=%b required 255 0", bin, err);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || bin !== 10'd255) begin
      bad++;
      $display("FAIL hold_after_done: got done=%b bin=%0d required 0 255", done, bin);
    end
  endtask

  task automatic test_values();
    runConversion(12'h999, 0);
    total++;
    if (bin !== 10'h3E7) begin
      bad++;
      $display("FAIL value_999: got %0d required 999", bin);
    end
    runConversion(12'h000, 0);
    total++;
    if (bin !== 10'd0) begin
      bad++;
      $display("FAIL value_000: got %0d required 0", bin);
    end
    runConversion(12'h001, 0);
    total++;
    if (bin !== 10'd1) begin
      bad++;
      $display("FAIL value_001: got %0d required 1", bin);
    end
  endtask

  task automatic test_invalid();
    runConversion(12'h1A3, 0);
    total++;
    if (err !== 1'b1 || bin !== 10'd0) begin
      bad++;
      $display("FAIL invalid_1A3: got err=%b bin=%0d required 1 0", err, bin);
    end
    runConversion(12'h042, 0);
    total++;
    if (err !== 1'b0 || bin !== 10'd42) begin
      bad++;
      $display("FAIL after_invalid_042: got err=%b bin=%0d required 0 42", err, bin);
    end
  endtask

  task automatic test_ignore_start();
    runConversion(12'h255, 4);
    total++;
    if (bin !== 10'd255) begin
      bad++;
      $display("FAIL ignore_start: got %0d required 255", bin);
    end
  endtask

  task automatic test_back_to_back();
    logic expBusy, expDone;
    start = 1'b1;
    bcd = 12'h123;
    sb.push_back(refModel(12'h123));
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 1) bcd = 12'h456;
      if (k == 11) begin
        total++;
        if (bin !== 10'd123) begin
          bad++;
          $display("FAIL b2b_first: got %0d required 123", bin);
        end
        sb.push_back(refModel(12'h456));
      end
      if (k == 12) start = 1'b0;
      expBusy = (k <= 10) || (k >= 12 && k <= 21);
      expDone = (k == 11) || (k == 22);
      total++;
      if (busy !== expBusy || done !== expDone) begin
        bad++;
        $display("FAIL b2b_edge%0d: got busy=%b done=%b required %b %b",
                 k, busy, done, expBusy, expDone);
      end
    end
    total++;
    if (bin !== 10'd456) begin
      bad++;
      $display("FAIL b2b_second: got %0d required 456", bin);
    end
  endtask

  task automatic test_reset_mid();
    int doneBefore;
    @(posedge clk); #1;
    start = 1'b1;
    bcd = 12'h555;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bin, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got bin=%0d busy=%b done=%b err=%b required all 0",
               bin, busy, done, err);
    end
    doneBefore = doneSeen;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    total++;
    if (doneSeen !== doneBefore || busy !== 1'b0) begin
      bad++;
      $display("FAIL abandoned_conv: got dones=%0d busy=%b required %0d 0",
               doneSeen - doneBefore, busy, 0);
    end
    runConversion(12'h100, 0);
    total++;
    if (bin !== 10'd100) begin
      bad++;
      $display("FAIL after_reset_100: got %0d required 100", bin);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] v;
    int pos;
    for (int i = 0; i < 1000; i++) begin
      v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      runConversion(v, 0);
    end
    for (int n = 0; n < 40; n++) begin
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      pos = $urandom_range(0, 2);
      v[pos*4 +: 4] = 4'($urandom_range(10, 15));
      runConversion(v, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
